// File: rtl/ifetch_controller.sv
// ifetch_controller: instruction-fetch sequencer.
// Owns the program counter, issues one instruction-memory request at a time,
// holds each fetched word until decode accepts it, and squashes in-flight or
// held instructions when execute redirects the fetch stream.
// Optional feature: define IFETCH_ALIGN_CHECK_EN to trap misaligned redirect
// targets (adds fault/fault_pc ports and a HALT state). Without it, the low
// two bits of a redirect target are cleared when loaded into the PC.
module ifetch_controller #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
`ifdef IFETCH_ALIGN_CHECK_EN
    output logic        fault,
    output logic [31:0] fault_pc,
`endif
    output logic [31:0] pc
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        FULL = 3'd3
`ifdef IFETCH_ALIGN_CHECK_EN
        ,
        HALT = 3'd4
`endif
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] req_pc_q;
    logic        kill_q;
    logic [31:0] inst_data_q;
    logic [31:0] inst_pc_q;

    // Sequential successor of the fetch address (wraps modulo 2^32) and the
    // word-aligned redirect target.
    logic [31:0] pc_inc_d;
    logic [31:0] redir_tgt_d;
    assign pc_inc_d    = pc_q + 32'd4;
    assign redir_tgt_d = redirect_pc & ~32'h0000_0003;

`ifdef IFETCH_ALIGN_CHECK_EN
    logic        fault_q;
    logic [31:0] fault_pc_q;
    logic        misaligned_d;
    assign misaligned_d = redirect_valid && (redirect_pc[1:0] != 2'b00);
`endif

    // Fetch FSM: request issue, response capture, decode handoff, redirect/kill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            req_pc_q    <= 32'h0;
            kill_q      <= 1'b0;
            inst_data_q <= 32'h0;
            inst_pc_q   <= 32'h0;
`ifdef IFETCH_ALIGN_CHECK_EN
            fault_q     <= 1'b0;
            fault_pc_q  <= 32'h0;
`endif
        end else begin
`ifdef IFETCH_ALIGN_CHECK_EN
            if (misaligned_d && (state_q != HALT)) begin
                // Trap: stop fetching; anything in flight is simply ignored.
                fault_q    <= 1'b1;
                fault_pc_q <= redirect_pc;
                kill_q     <= 1'b0;
                state_q    <= HALT;
            end else begin
`endif
            case (state_q)
                IDLE: begin
                    state_q <= REQ;
                    if (redirect_valid) pc_q <= redir_tgt_d;
                end
                REQ: begin
                    if (imem_req_ready) begin
                        // Old address is accepted; a simultaneous redirect
                        // marks its response for discard.
                        req_pc_q <= pc_q;
                        pc_q     <= redirect_valid ? redir_tgt_d : pc_inc_d;
                        kill_q   <= redirect_valid;
                        state_q  <= WAIT;
                    end else if (redirect_valid) begin
                        pc_q <= redir_tgt_d;
                    end
                end
                WAIT: begin
                    if (redirect_valid) pc_q <= redir_tgt_d;
                    if (imem_rsp_valid) begin
                        if (kill_q || redirect_valid) begin
                            kill_q  <= 1'b0;
                            state_q <= REQ;
                        end else begin
                            inst_data_q <= imem_rsp_data;
                            inst_pc_q   <= req_pc_q;
                            state_q     <= FULL;
                        end
                    end else if (redirect_valid) begin
                        kill_q <= 1'b1;
                    end
                end
                FULL: begin
                    if (redirect_valid) begin
                        pc_q    <= redir_tgt_d;
                        state_q <= REQ;
                    end else if (inst_ready) begin
                        state_q <= REQ;
                    end
                end
`ifdef IFETCH_ALIGN_CHECK_EN
                HALT: begin
                    state_q <= HALT;
                end
`endif
                default: begin
                    state_q <= IDLE;
                end
            endcase
`ifdef IFETCH_ALIGN_CHECK_EN
            end
`endif
        end
    end

    assign imem_req_valid = (state_q == REQ);
    assign imem_req_addr  = pc_q;
    assign inst_valid     = (state_q == FULL);
    assign inst_data      = inst_data_q;
    assign inst_pc        = inst_pc_q;
    assign pc             = pc_q;
`ifdef IFETCH_ALIGN_CHECK_EN
    assign fault          = fault_q;
    assign fault_pc       = fault_pc_q;
`endif

endmodule

// File: tb/tb_ifetch_controller.sv
// Directed bench for ifetch_controller: a cycle table for steady-state fetch
// and decode back-pressure, then hand sequences for redirect corner cases,
// PC wrap, alignment handling and asynchronous reset.
module tb_ifetch_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] pc;
`ifdef IFETCH_ALIGN_CHECK_EN
    logic        fault;
    logic [31:0] fault_pc;
`endif

    int tests = 0;
    int fails = 0;
    int consumed = 0;

    ifetch_controller #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
`ifdef IFETCH_ALIGN_CHECK_EN
        .fault          (fault),
        .fault_pc       (fault_pc),
`endif
        .pc             (pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rr;
        logic        rspv;
        logic [31:0] rspd;
        logic        ir;
        logic        dv;
        logic [31:0] dpc;
        logic        e_rv;
        logic        e_iv;
        logic [31:0] e_id;
        logic [31:0] e_ipc;
        logic [31:0] e_pc;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs after the falling edge, then check the outputs
    // produced by the previous rising edge.
    task automatic step(input logic rr, input logic rspv, input logic [31:0] rspd,
                        input logic ir, input logic dv, input logic [31:0] dpc,
                        input logic e_rv, input logic e_iv, input logic [31:0] e_id,
                        input logic [31:0] e_ipc, input logic [31:0] e_pc,
                        input string nm);
        @(negedge clk);
        imem_req_ready = rr;
        imem_rsp_valid = rspv;
        imem_rsp_data  = rspd;
        inst_ready     = ir;
        redirect_valid = dv;
        redirect_pc    = dpc;
        #1;
        chk({nm, ".req_valid"}, {31'h0, imem_req_valid}, {31'h0, e_rv});
        chk({nm, ".inst_valid"}, {31'h0, inst_valid}, {31'h0, e_iv});
        chk({nm, ".pc"}, pc, e_pc);
        chk({nm, ".req_addr"}, imem_req_addr, e_pc);
        if (e_iv) begin
            chk({nm, ".inst_data"}, inst_data, e_id);
            chk({nm, ".inst_pc"}, inst_pc, e_ipc);
        end
        if (inst_valid && ir) consumed++;
    endtask

    vec_t tbl[17];
    int   cons0;

    initial begin
        //            rr  rspv rspd           ir  dv  dpc   e_rv e_iv e_id           e_ipc  e_pc
        tbl[0]  = '{1'b1,1'b0,32'h0,         1'b1,1'b0,32'h0,1'b1,1'b0,32'h0,         32'h0, 32'h0};
        tbl[1]  = '{1'b1,1'b1,32'h1300_0000, 1'b1,1'b0,32'h0,1'b0,1'b0,32'h0,         32'h0, 32'h4};
        tbl[2]  = '{1'b1,1'b0,32'h0,         1'b1,1'b0,32'h0,1'b0,1'b1,32'h1300_0000, 32'h0, 32'h4};
        tbl[3]  = '{1'b1,1'b0,32'h0,         1'b1,1'b0,32'h0,1'b1,1'b0,32'h0,         32'h0, 32'h4};
        tbl[4]  = '{1'b1,1'b1,32'h1300_0004, 1'b1,1'b0,32'h0,1'b0,1'b0,32'h0,         32'h0, 32'h8};
        tbl[5]  = '{1'b1,1'b0,32'h0,         1'b1,1'b0,32'h0,1'b0,1'b1,32'h1300_0004, 32'h4, 32'h8};
        tbl[6]  = '{1'b1,1'b0,32'h0,         1'b1,1'b0,32'h0,1'b1,1'b0,32'h0,         32'h0, 32'h8};
        tbl[7]  = '{1'b1,1'b1,32'h1300_0008, 1'b1,1'b0,32'h0,1'b0,1'b0,32'h0,         32'h0, 32'hC};
        tbl[8]  = '{1'b1,1'b0,32'h0,         1'b0,1'b0,32'h0,1'b0,1'b1,32'h1300_0008, 32'h8, 32'hC};
        tbl[9]  = '{1'b1,1'b1,32'hDEAD_BEEF, 1'b0,1'b0,32'h0,1'b0,1'b1,32'h1300_0008, 32'h8, 32'hC};
        tbl[10] = '{1'b1,1'b0,32'h0,         1'b0,1'b0,32'h0,1'b0,1'b1,32'h1300_0008, 32'h8, 32'hC};
        tbl[11] = '{1'b1,1'b0,32'h0,         1'b0,1'b0,32'h0,1'b0,1'b1,32'h1300_0008, 32'h8, 32'hC};
        tbl[12] = '{1'b1,1'b0,32'h0,         1'b0,1'b0,32'h0,1'b0,1'b1,32'h1300_0008, 32'h8, 32'hC};
        tbl[13] = '{1'b1,1'b0,32'h0,         1'b1,1'b0,32'h0,1'b0,1'b1,32'h1300_0008, 32'h8, 32'hC};
        tbl[14] = '{1'b1,1'b0,32'h0,         1'b1,1'b0,32'h0,1'b1,1'b0,32'h0,         32'h0, 32'hC};
        tbl[15] = '{1'b1,1'b1,32'h1300_000C, 1'b1,1'b0,32'h0,1'b0,1'b0,32'h0,         32'h0, 32'h10};
        tbl[16] = '{1'b1,1'b0,32'h0,         1'b1,1'b0,32'h0,1'b0,1'b1,32'h1300_000C, 32'hC, 32'h10};

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst.req_valid", {31'h0, imem_req_valid}, 32'h0);
        chk("rst.inst_valid", {31'h0, inst_valid}, 32'h0);
        chk("rst.pc", pc, 32'h0);
        chk("rst.inst_data", inst_data, 32'h0);
        chk("rst.inst_pc", inst_pc, 32'h0);
`ifdef IFETCH_ALIGN_CHECK_EN
        chk("rst.fault", {31'h0, fault}, 32'h0);
        chk("rst.fault_pc", fault_pc, 32'h0);
`endif
        // Release; first cycle after release is IDLE, request rises in the 2nd.
        @(negedge clk);
        rst_n = 1'b1;
        imem_req_ready = 1'b1;
        inst_ready = 1'b1;
        #1;
        chk("idle.req_valid", {31'h0, imem_req_valid}, 32'h0);

        for (int i = 0; i < 17; i++) begin
            step(tbl[i].rr, tbl[i].rspv, tbl[i].rspd, tbl[i].ir, tbl[i].dv, tbl[i].dpc,
                 tbl[i].e_rv, tbl[i].e_iv, tbl[i].e_id, tbl[i].e_ipc, tbl[i].e_pc,
                 $sformatf("tbl%0d", i));
        end
        chk("tbl.consumed", consumed, 32'd4);

        // Redirect during WAIT, killed response arrives 3 cycles later
        step(1,0,32'h0,        1,0,32'h0,   1,0,32'h0,32'h0,32'h10, "A0");
        step(0,0,32'h0,        1,1,32'h100, 0,0,32'h0,32'h0,32'h14, "A1");
        step(0,0,32'h0,        1,0,32'h0,   0,0,32'h0,32'h0,32'h100,"A2");
        step(0,0,32'h0,        1,0,32'h0,   0,0,32'h0,32'h0,32'h100,"A3");
        step(0,1,32'hBADB_AD00,1,0,32'h0,   0,0,32'h0,32'h0,32'h100,"A4");
        step(1,0,32'h0,        1,0,32'h0,   1,0,32'h0,32'h0,32'h100,"A5");
        step(0,1,32'h1300_0100,1,0,32'h0,   0,0,32'h0,32'h0,32'h104,"A6");
        // Redirect in FULL without decode handshake: held word is dropped
        step(0,0,32'h0,        0,1,32'h8,   0,1,32'h1300_0100,32'h100,32'h104,"A7");

        // Redirect in the same cycle the request at 0x8 is accepted
        step(1,0,32'h0,        1,1,32'h40,  1,0,32'h0,32'h0,32'h8,  "B0");
        step(0,1,32'h1300_0008,1,0,32'h0,   0,0,32'h0,32'h0,32'h40, "B1");
        step(1,0,32'h0,        1,0,32'h0,   1,0,32'h0,32'h0,32'h40, "B2");
        step(0,1,32'h1300_0040,1,0,32'h0,   0,0,32'h0,32'h0,32'h44, "B3");
        cons0 = consumed;
        // Redirect in FULL together with inst_ready
        step(0,0,32'h0,        1,1,32'h200, 0,1,32'h1300_0040,32'h40,32'h44,"B4");
        step(1,0,32'h0,        1,0,32'h0,   1,0,32'h0,32'h0,32'h200,"C0");
        step(0,1,32'h1300_0200,1,0,32'h0,   0,0,32'h0,32'h0,32'h204,"C1");
        step(0,0,32'h0,        1,0,32'h0,   0,1,32'h1300_0200,32'h200,32'h204,"C2");
        chk("C.consumed", consumed - cons0, 32'd2);

        // Redirect in REQ without ready; address then holds while stalled
        step(0,0,32'h0,        1,1,32'h300, 1,0,32'h0,32'h0,32'h204,"D0");
        step(0,0,32'h0,        1,0,32'h0,   1,0,32'h0,32'h0,32'h300,"D1");
        step(1,0,32'h0,        1,0,32'h0,   1,0,32'h0,32'h0,32'h300,"D2");
        // Redirect in WAIT with the response in the same cycle
        step(0,1,32'h1300_0300,1,1,32'h400, 0,0,32'h0,32'h0,32'h304,"D3");
        step(0,0,32'h0,        1,1,32'hFFFF_FFFC,1,0,32'h0,32'h0,32'h400,"D4");

        // PC+4 wraps to zero
        step(1,0,32'h0,        1,0,32'h0,   1,0,32'h0,32'h0,32'hFFFF_FFFC,"W0");
        step(0,1,32'h1300_FFFC,1,0,32'h0,   0,0,32'h0,32'h0,32'h0,  "W1");
        step(0,0,32'h0,        1,0,32'h0,   0,1,32'h1300_FFFC,32'hFFFF_FFFC,32'h0,"W2");

        // Misaligned redirect target
        step(0,0,32'h0,        1,1,32'h102, 1,0,32'h0,32'h0,32'h0,  "E0");
`ifdef IFETCH_ALIGN_CHECK_EN
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            imem_req_ready = 1'b1;
            imem_rsp_valid = (i == 1);
            redirect_valid = 1'b0;
            #1;
            chk($sformatf("E%0d.req_valid", i + 1), {31'h0, imem_req_valid}, 32'h0);
            chk($sformatf("E%0d.inst_valid", i + 1), {31'h0, inst_valid}, 32'h0);
            chk($sformatf("E%0d.fault", i + 1), {31'h0, fault}, 32'h1);
            chk($sformatf("E%0d.fault_pc", i + 1), fault_pc, 32'h102);
        end
`else
        step(1,0,32'h0,        1,0,32'h0,   1,0,32'h0,32'h0,32'h100,"E1");
        step(0,1,32'h1300_0100,1,0,32'h0,   0,0,32'h0,32'h0,32'h104,"E2");
        step(0,0,32'h0,        0,0,32'h0,   0,1,32'h1300_0100,32'h100,32'h104,"E3");
`endif

        // Asynchronous reset mid-operation
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst.req_valid", {31'h0, imem_req_valid}, 32'h0);
        chk("mrst.inst_valid", {31'h0, inst_valid}, 32'h0);
        chk("mrst.pc", pc, 32'h0);
        chk("mrst.inst_data", inst_data, 32'h0);
        chk("mrst.inst_pc", inst_pc, 32'h0);
`ifdef IFETCH_ALIGN_CHECK_EN
        chk("mrst.fault", {31'h0, fault}, 32'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        step(1,0,32'h0,        1,0,32'h0,   1,0,32'h0,32'h0,32'h0,  "R0");
        step(0,1,32'h1300_0000,1,0,32'h0,   0,0,32'h0,32'h0,32'h4,  "R1");
        step(0,0,32'h0,        1,0,32'h0,   0,1,32'h1300_0000,32'h0,32'h4,"R2");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
